// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 constants, address type and loader state encoding
//   MEM_SIZE     : program memory depth in bytes
//   LOAD_BASE    : first address written by the loader (cpu reset pc)
//   LOADER_MAGIC : frame start byte
//   addr_t       : 12-bit memory address, shared with the cpu
package chip8_pkg;

  localparam int MEM_SIZE = 4096;

  typedef logic [11:0] addr_t;

  localparam addr_t      LOAD_BASE    = 12'h200;
  localparam logic [7:0] LOADER_MAGIC = 8'hC8;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/chip8_loader.sv
// rtl/chip8_loader.sv - framed byte-stream loader that writes the CHIP-8 program image and gates cpu_run
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_data     : input byte stream (transfer when in_valid && in_ready)
//   in_ready             : always 1 outside reset; every byte is consumed in one cycle
//   mem_we/addr/wdata    : program memory write port, one cycle after the data byte is accepted
//   cpu_run              : cpu may execute (only after a verified image)
//   done / error         : last frame verified / last frame rejected
module chip8_loader
  import chip8_pkg::*;
#(
  parameter addr_t      LOAD_BASE = chip8_pkg::LOAD_BASE,
  parameter int         MEM_SIZE  = chip8_pkg::MEM_SIZE,
  parameter logic [7:0] MAGIC     = chip8_pkg::LOADER_MAGIC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        error
);

  // Largest payload that still fits in [LOAD_BASE, MEM_SIZE); 13 bits so 0x1000 is representable.
  localparam logic [12:0] MAX_LEN = 13'(MEM_SIZE - int'(LOAD_BASE));

  loader_state_t r_state;
  logic [3:0]    r_len_hi;
  logic [11:0]   r_cnt;
  addr_t         r_ptr;
  logic [7:0]    r_sum;
  logic          r_in_ready;
  logic          r_mem_we;
  addr_t         r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_cpu_run;
  logic          r_done;
  logic          r_error;

  logic          w_accept;
  logic [11:0]   w_len;

  assign w_accept = in_valid && r_in_ready;
  assign w_len    = {r_len_hi, in_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_len_hi    <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_sum       <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_run   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      // Write strobe is a single-cycle pulse; address/data hold their last value.
      r_mem_we   <= 1'b0;

      if (w_accept) begin
        unique case (r_state)
          IDLE: begin
            if (in_data == MAGIC) r_state <= LEN_HI;
          end

          LEN_HI: begin
            r_len_hi <= in_data[3:0];
            if (in_data[7:4] != 4'd0) begin
              r_error <= 1'b1;
              r_state <= ERROR;
            end else begin
              r_state <= LEN_LO;
            end
          end

          LEN_LO: begin
            r_sum <= '0;
            r_ptr <= LOAD_BASE;
            r_cnt <= w_len;
            if ({1'b0, w_len} > MAX_LEN) begin
              r_error <= 1'b1;
              r_state <= ERROR;
            end else if (w_len == 12'd0) begin
              r_state <= CSUM;
            end else begin
              r_state <= DATA;
            end
          end

          DATA: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= in_data;
            r_ptr       <= r_ptr + 12'd1;
            r_sum       <= r_sum + in_data;
            r_cnt       <= r_cnt - 12'd1;
            if (r_cnt == 12'd1) r_state <= CSUM;
          end

          CSUM: begin
            // Earliest checksum accept is the edge after the last write pulse,
            // so cpu_run can never rise over a partially written image.
            if (in_data == r_sum) begin
              r_done    <= 1'b1;
              r_cpu_run <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_error <= 1'b1;
              r_state <= ERROR;
            end
          end

          DONE: begin
            if (in_data == MAGIC) begin
              r_done    <= 1'b0;
              r_cpu_run <= 1'b0;
              r_state   <= LEN_HI;
            end
          end

          ERROR: begin
            if (in_data == MAGIC) begin
              r_error <= 1'b0;
              r_state <= LEN_HI;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_run   = r_cpu_run;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: doc/chip8_loader.md
Name: chip8_loader

Overview:
Byte-stream program loader, the write side of the CHIP-8 program memory that the cpu fetches from. Accepts a framed image (magic, 12-bit length, payload, checksum) on a valid/ready byte interface and writes the payload into memory starting at LOAD_BASE. While loading, it holds the cpu halted. On a verified image it releases the cpu via cpu_run; on a bad frame it latches error and keeps the cpu halted.

Parameters:
LOAD_BASE, 12'h200, first memory address written (cpu reset pc).
MEM_SIZE, 4096, memory depth in bytes; the payload must fit in [LOAD_BASE, MEM_SIZE).
MAGIC, 8'hC8, frame start byte.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data holds a byte.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte; a transfer happens when in_valid && in_ready on a clk edge.
mem_we  output  1  write strobe to program memory, one cycle per byte.
mem_addr  output  12  write address.
mem_wdata  output  8  write data.
cpu_run  output  1  high = cpu may execute; low = cpu held at fetch start.
done  output  1  level; the last frame loaded and verified.
error  output  1  level; the last frame was rejected.

Behaviour:
- Interface: clock and reset are a single clk with asynchronous active-high reset.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, done=0, error=0. The state is IDLE and the sum and counter are cleared. in_ready goes to 1 on the first edge after reset deasserts.
- in_ready is 1 in every non-reset state. The block never back-pressures, and every accepted byte is consumed in one cycle.
- States:
  - IDLE: accepted byte == MAGIC goes to LEN_HI. Any other byte is dropped and the state stays IDLE.
  - LEN_HI: len[11:8] = in_data[3:0]. in_data[7:4] != 0 goes to ERROR. Otherwise go to LEN_LO.
  - LEN_LO: len[7:0] = in_data.
    - len > MEM_SIZE-LOAD_BASE (0xE00 by default) goes to ERROR.
    - len == 0 goes to CSUM.
    - Otherwise go to DATA, with the write pointer set to LOAD_BASE and the sum cleared.
  - DATA: each accepted byte is registered to mem_wdata/mem_addr with mem_we=1 on the next cycle. The write pointer increments and sum += byte (mod 256). After len bytes, go to CSUM.
  - CSUM: accepted byte == sum goes to DONE. A mismatch goes to ERROR.
  - DONE: done=1, cpu_run=1. An accepted MAGIC byte restarts the load: done=0 and cpu_run=0 on that same edge, then LEN_HI. Other bytes are ignored.
  - ERROR: error=1, cpu_run=0. An accepted MAGIC byte clears error and goes to LEN_HI. Other bytes are ignored.
- Write latency: exactly 1 cycle from the byte-accept edge to mem_we high. mem_we is low in every cycle without a data write. mem_addr/mem_wdata hold their last value when mem_we=0.
- Address never wraps. The length check guarantees the last write is at LOAD_BASE+len-1 <= MEM_SIZE-1.
- Memory outside the written range is not touched, so prior contents persist.
- cpu_run rises on the edge that enters DONE. This is one cycle after the last mem_we, so the cpu never fetches a half-written image.
- in_valid low stalls any state indefinitely, with no timeout.
- Reset asserted mid-frame aborts immediately to reset values; a partial image stays in memory, but cpu_run=0.

Decomposition:
- Shared package chip8_pkg:
  - MEM_SIZE, LOAD_BASE, LOADER_MAGIC constants.
  - Loader state enum: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
  - 12-bit address type, shared with cpu.
- No sub-module. A single FSM with a 12-bit count/pointer and an 8-bit accumulator.

Test Plan:
- Stream C8 00 03 60 42 12 B4 -> writes mem[200]=60, [201]=42, [202]=12, one mem_we per cycle, 1-cycle latency. done=1 and cpu_run=1 on the edge after B4; error=0.
- Same frame with checksum B5 -> 3 writes occur, then error=1, done=0, cpu_run=0. A following C8 00 00 00 -> done=1, error=0.
- C8 0E 01 -> error=1 after the third byte, with no mem_we ever. C8 1x .. -> error after the second byte.
- Garbage 00 FF 12 then a valid frame, with in_valid toggled randomly -> garbage dropped, image loaded exactly as a clean frame, with no extra writes.
- From DONE, send C8 00 01 AA AA -> cpu_run drops on the C8 accept edge, mem[200]=AA, then done again.
- Assert reset after 2 of 3 data bytes -> all outputs return to reset values asynchronously (before the next edge). A new full frame after release loads correctly.
